key_debounce_counter: RTL and testbench

//  Input-side counterpart to the counter-driven LED outputs: reads one board push-button (KEY, active-low,

---
 rtl/key_debounce_counter.sv | 119 +++++++++++
 tb/tb_key_debounce_counter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_counter.sv
// Push-button front end: 2-FF synchroniser, stable-sample debounce FSM,
// registered level and press/release pulses, and a wrapping press counter.
module key_debounce_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_n,
  output logic             key_level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic [CNT_W-1:0] press_count
);

  localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DCW-1:0] D_MAX = DCW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_e;

  logic [1:0]       sync_q;
  logic             sync_key_n;
  state_e           state_q, state_d;
  logic [DCW-1:0]   cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign sync_key_n    = sync_q[1];
  assign key_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign press_count   = count_q;

  // Synchroniser resets to the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= '0;
    end else begin
      sync_q    <= {sync_q[0], key_n};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    count_d   = count_q;

    unique case (state_q)
      IDLE: begin
        if (!sync_key_n) begin
          state_d = PRESS_WAIT;
          cnt_d   = DCW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (sync_key_n) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == D_MAX) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
          count_d = count_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q + DCW'(1);
        end
      end
      HELD: begin
        if (sync_key_n) begin
          state_d = RELEASE_WAIT;
          cnt_d   = DCW'(1);
        end
      end
      RELEASE_WAIT: begin
        if (!sync_key_n) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == D_MAX) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DCW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Level is registered alongside the state it is derived from.
    level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

endmodule

// File: tb/tb_key_debounce_counter.sv
// Bench for key_debounce_counter: directed and random key waveforms checked
// against a run-length model of the debounce rules.
module tb_key_debounce_counter;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b1;
  logic       key_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [7:0] press_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  key_debounce_counter #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_n        (key_n),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .press_count  (press_count)
  );

  always #5 clk = ~clk;

  // Reference: an edge is accepted on the (D+1)th consecutive synchronised
  // sample that disagrees with the accepted level; sync lags key_n by two edges.
  logic h0 = 1'b1, h1 = 1'b1;
  logic m_level = 1'b0;
  int   m_run = 0;
  logic [7:0] m_count = '0;
  int   m_press_n = 0, m_rel_n = 0, m_last_press = 0, m_last_rel = 0;
  int   mn_run;
  logic mn_level, mn_pp, mn_rp;

  always_comb begin
    mn_run   = ((!h1) != m_level) ? m_run + 1 : 0;
    mn_level = m_level;
    mn_pp    = 1'b0;
    mn_rp    = 1'b0;
    if (mn_run == D + 1) begin
      mn_level = !m_level;
      mn_run   = 0;
      mn_pp    = !m_level;
      mn_rp    = m_level;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      h0      <= 1'b1;
      h1      <= 1'b1;
      m_level <= 1'b0;
      m_run   <= 0;
      m_count <= '0;
    end else begin
      h0      <= key_n;
      h1      <= h0;
      m_level <= mn_level;
      m_run   <= mn_run;
      if (mn_pp) begin
        m_count      <= m_count + 8'd1;
        m_press_n    <= m_press_n + 1;
        m_last_press <= cyc + 1;
      end
      if (mn_rp) begin
        m_rel_n    <= m_rel_n + 1;
        m_last_rel <= cyc + 1;
      end
    end
  end

  // DUT pulse monitor: totals, timestamps and pulse-rule violations.
  int   d_press_n = 0, d_rel_n = 0, d_last_press = 0, d_last_rel = 0, d_bad = 0;
  logic prev_any = 1'b0;

  always @(negedge clk) begin
    if (press_pulse) begin
      d_press_n    <= d_press_n + 1;
      d_last_press <= cyc;
    end
    if (release_pulse) begin
      d_rel_n    <= d_rel_n + 1;
      d_last_rel <= cyc;
    end
    if ((press_pulse && release_pulse) || ((press_pulse || release_pulse) && prev_any))
      d_bad <= d_bad + 1;
    prev_any <= press_pulse | release_pulse;
  end

  task automatic hold(input logic k, input int n);
    key_n = k;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    key_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({key_level, press_pulse, release_pulse, press_count} !== 11'd0) begin
      errors++;
      $display("FAIL reset_in: got lvl=%b pp=%b rp=%b cnt=%0d want all 0",
               key_level, press_pulse, release_pulse, press_count);
    end
    rst_n = 1'b1;
    hold(1'b1, 4);
    checks++;
    if ({key_level, press_pulse, release_pulse, press_count} !== 11'd0) begin
      errors++;
      $display("FAIL reset_after: got lvl=%b pp=%b rp=%b cnt=%0d want all 0",
               key_level, press_pulse, release_pulse, press_count);
    end
  endtask

  task automatic test_clean_press;
    int e0 = cyc + 1;
    hold(1'b0, 20);
    checks++;
    if (d_last_press !== e0 + 10) begin
      errors++;
      $display("FAIL press_latency: got cycle %0d want %0d", d_last_press, e0 + 10);
    end
    checks++;
    if (d_press_n !== 1) begin
      errors++;
      $display("FAIL press_once: got %0d pulses want 1", d_press_n);
    end
    checks++;
    if (key_level !== 1'b1 || press_count !== 8'd1) begin
      errors++;
      $display("FAIL press_state: got lvl=%b cnt=%0d want lvl=1 cnt=1", key_level, press_count);
    end
  endtask

  task automatic test_release;
    logic [7:0] c = press_count;
    int e0 = cyc + 1;
    int r0;
    hold(1'b1, 20);
    checks++;
    if (d_last_rel !== e0 + 10) begin
      errors++;
      $display("FAIL release_latency: got cycle %0d want %0d", d_last_rel, e0 + 10);
    end
    checks++;
    if (key_level !== 1'b0 || press_count !== c) begin
      errors++;
      $display("FAIL release_state: got lvl=%b cnt=%0d want lvl=0 cnt=%0d", key_level, press_count, c);
    end
    hold(1'b0, 20);
    r0 = d_rel_n;
    hold(1'b1, 3);
    hold(1'b0, 3);
    hold(1'b0, 15);
    checks++;
    if (d_rel_n !== r0 || key_level !== 1'b1) begin
      errors++;
      $display("FAIL release_glitch: got rels=%0d lvl=%b want rels=%0d lvl=1", d_rel_n, key_level, r0);
    end
    hold(1'b1, 20);
    checks++;
    if (d_rel_n !== r0 + 1 || press_count !== c + 8'd1) begin
      errors++;
      $display("FAIL release_after_glitch: got rels=%0d cnt=%0d want rels=%0d cnt=%0d",
               d_rel_n, press_count, r0 + 1, c + 8'd1);
    end
  endtask

  task automatic test_bounce;
    int p0 = d_press_n;
    logic [7:0] c = press_count;
    hold(1'b0, 5);
    hold(1'b1, 2);
    hold(1'b0, 5);
    hold(1'b1, 20);
    checks++;
    if (d_press_n !== p0 || press_count !== c || key_level !== 1'b0) begin
      errors++;
      $display("FAIL bounce: got presses=%0d cnt=%0d lvl=%b want presses=%0d cnt=%0d lvl=0",
               d_press_n, press_count, key_level, p0, c);
    end
  endtask

  task automatic test_random;
    logic k = 1'b1;
    for (int i = 0; i < 60; i++) begin
      k = ~k;
      hold(k, $urandom_range(1, 13));
    end
    hold(1'b1, 25);
    checks++;
    if (d_press_n !== m_press_n || d_rel_n !== m_rel_n) begin
      errors++;
      $display("FAIL random_pulses: got p=%0d r=%0d want p=%0d r=%0d", d_press_n, d_rel_n, m_press_n, m_rel_n);
    end
    checks++;
    if (d_last_press !== m_last_press || d_last_rel !== m_last_rel) begin
      errors++;
      $display("FAIL random_timing: got p@%0d r@%0d want p@%0d r@%0d",
               d_last_press, d_last_rel, m_last_press, m_last_rel);
    end
    checks++;
    if (press_count !== m_count || key_level !== m_level) begin
      errors++;
      $display("FAIL random_state: got cnt=%0d lvl=%b want cnt=%0d lvl=%b", press_count, key_level, m_count, m_level);
    end
  endtask

  task automatic test_wrap;
    int p0, r0;
    rst_n = 1'b0;
    hold(1'b1, 3);
    rst_n = 1'b1;
    hold(1'b1, 3);
    p0 = d_press_n;
    r0 = d_rel_n;
    for (int i = 0; i < 255; i++) begin
      hold(1'b0, 12);
      hold(1'b1, 12);
    end
    checks++;
    if (press_count !== 8'd255) begin
      errors++;
      $display("FAIL wrap_255: got cnt=%0d want 255", press_count);
    end
    hold(1'b0, 12);
    hold(1'b1, 12);
    checks++;
    if (press_count !== 8'd0) begin
      errors++;
      $display("FAIL wrap_0: got cnt=%0d want 0", press_count);
    end
    checks++;
    if (d_press_n - p0 !== 256 || d_rel_n - r0 !== 256) begin
      errors++;
      $display("FAIL wrap_pulses: got p=%0d r=%0d want 256 each", d_press_n - p0, d_rel_n - r0);
    end
  endtask

  task automatic test_held;
    int p0 = d_press_n;
    int lows = 0;
    hold(1'b0, 10);
    for (int i = 0; i < 990; i++) begin
      hold(1'b0, 1);
      if (key_level !== 1'b1) lows++;
    end
    checks++;
    if (lows !== 0) begin
      errors++;
      $display("FAIL held_level: got %0d cycles with lvl=0 want 0", lows);
    end
    checks++;
    if (d_press_n - p0 !== 1 || press_count !== m_count) begin
      errors++;
      $display("FAIL held_once: got %0d presses cnt=%0d want 1 cnt=%0d", d_press_n - p0, press_count, m_count);
    end
    hold(1'b1, 20);
  endtask

  task automatic test_reset_midop;
    int p0;
    int e0;
    key_n = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    checks++;
    if (press_count !== 8'd1 || key_level !== 1'b0) begin
      errors++;
      $display("FAIL midop_pre: got cnt=%0d lvl=%b want cnt=1 lvl=0", press_count, key_level);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({key_level, press_pulse, release_pulse, press_count} !== 11'd0) begin
      errors++;
      $display("FAIL midop_async: got lvl=%b pp=%b rp=%b cnt=%0d want all 0",
               key_level, press_pulse, release_pulse, press_count);
    end
    repeat (3) @(negedge clk);
    #1;
    p0 = d_press_n;
    rst_n = 1'b1;
    e0 = cyc + 1;
    hold(1'b0, 15);
    checks++;
    if (d_last_press !== e0 + 10 || d_press_n - p0 !== 1) begin
      errors++;
      $display("FAIL midop_requal: got p@%0d n=%0d want p@%0d n=1", d_last_press, d_press_n - p0, e0 + 10);
    end
    checks++;
    if (press_count !== 8'd1 || key_level !== 1'b1) begin
      errors++;
      $display("FAIL midop_state: got cnt=%0d lvl=%b want cnt=1 lvl=1", press_count, key_level);
    end
    hold(1'b1, 20);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_random();
    test_wrap();
    test_held();
    test_reset_midop();
    checks++;
    if (d_bad !== 0) begin
      errors++;
      $display("FAIL pulse_rules: got %0d overlapping/consecutive pulses want 0", d_bad);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
